serializer: RTL and testbench

SERIALIZER -- requirements
Module: serializer

---
 rtl/serializer.sv | 100 ++++++++++
 tb/tb_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// MSB-first parallel-to-serial shifter with a programmable word length.
// Every output comes straight from a flop, so no input reaches an output combinationally.
//
// state | meaning
// IDLE  | waiting for a request; all outputs are low
// SHIFT | emitting the captured word one bit per cycle, MSB first
module serializer #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [MOD_W:0] CNT_ONE  = (MOD_W+1)'(1);
    localparam logic [MOD_W:0] LEN_MIN  = (MOD_W+1)'(3);
    localparam logic [MOD_W:0] LEN_FULL = (MOD_W+1)'(DATA_W);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [MOD_W:0]     cnt_q, cnt_d;
    logic               ser_d, val_d, busy_d;
    logic [MOD_W:0]     len;
    logic               accept;

    // A length field of zero stands for a full word; the counter has one
    // extra bit so that a full word never aliases to zero.
    assign len    = (data_mod_i == '0) ? LEN_FULL : {1'b0, data_mod_i};
    assign accept = data_val_i && !busy_o && (state_q == IDLE) && (len >= LEN_MIN);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            cnt_q          <= '0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            cnt_q          <= cnt_d;
            ser_data_o     <= ser_d;
            ser_data_val_o <= val_d;
            busy_o         <= busy_d;
        end
    end

    // The first bit is launched on the same edge that captures the word.
    // From then on, cnt_q counts the bits that are still waiting to be sent.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ser_d   = 1'b0;
        val_d   = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    ser_d   = data_i[DATA_W-1];
                    val_d   = 1'b1;
                    busy_d  = 1'b1;
                    shift_d = {data_i[DATA_W-2:0], 1'b0};
                    cnt_d   = len - CNT_ONE;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    ser_d   = shift_q[DATA_W-1];
                    val_d   = 1'b1;
                    busy_d  = 1'b1;
                    shift_d = {shift_q[DATA_W-2:0], 1'b0};
                    cnt_d   = cnt_q - CNT_ONE;
                end else begin
                    state_d = IDLE;
                    shift_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_serializer.sv
// Directed and randomized checks of the serializer: bit order, word lengths,
// dropped short requests, back-to-back words and asynchronous reset.
module tb_serializer;

    logic        clk_i = 1'b0;
    logic        arst_n_i = 1'b0;
    logic [15:0] data_i = '0;
    logic [3:0]  data_mod_i = '0;
    logic        data_val_i = 1'b0;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        busy_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    serializer #(.DATA_W(16), .MOD_W(4)) dut (
        .clk_i          (clk_i),
        .arst_n_i       (arst_n_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_val_i     (data_val_i),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Observed vector is {busy_o, ser_data_val_o, ser_data_o}.
    task automatic test_reset();
        logic [2:0] obs;
        arst_n_i = 1'b0;
        #3;
        obs = {busy_o, ser_data_val_o, ser_data_o};
        chk_cnt++;
        if (obs !== 3'b000) $display("FAIL reset_async obs=%b exp=000", obs);
        else pass_cnt++;
        repeat (3) @(negedge clk_i);
        obs = {busy_o, ser_data_val_o, ser_data_o};
        chk_cnt++;
        if (obs !== 3'b000) $display("FAIL reset_held obs=%b exp=000", obs);
        else pass_cnt++;
        #2 arst_n_i = 1'b1;
        @(negedge clk_i);
        obs = {busy_o, ser_data_val_o, ser_data_o};
        chk_cnt++;
        if (obs !== 3'b000) $display("FAIL reset_release obs=%b exp=000", obs);
        else pass_cnt++;
    endtask

    task automatic test_full_word();
        logic [15:0] w;
        logic [2:0]  obs, exp;
        w = 16'hA5F0;
        data_i = w; data_mod_i = 4'd0; data_val_i = 1'b1;
        @(negedge clk_i);
        data_val_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp = {2'b11, w[15-k]};
            obs = {busy_o, ser_data_val_o, ser_data_o};
            chk_cnt++;
            if (obs !== exp) $display("FAIL full_word bit%0d obs=%b exp=%b", k, obs, exp);
            else pass_cnt++;
            @(negedge clk_i);
        end
        for (int k = 0; k < 2; k++) begin
            obs = {busy_o, ser_data_val_o, ser_data_o};
            chk_cnt++;
            if (obs !== 3'b000) $display("FAIL full_word_idle%0d obs=%b exp=000", k, obs);
            else pass_cnt++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_partial_word();
        logic [2:0] obs, exp;
        logic [2:0] bits;
        bits = 3'b110;
        data_i = 16'hC000; data_mod_i = 4'd3; data_val_i = 1'b1;
        @(negedge clk_i);
        data_val_i = 1'b0;
        data_i = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            exp = {2'b11, bits[2-k]};
            obs = {busy_o, ser_data_val_o, ser_data_o};
            chk_cnt++;
            if (obs !== exp) $display("FAIL partial bit%0d obs=%b exp=%b", k, obs, exp);
            else pass_cnt++;
            @(negedge clk_i);
        end
        for (int k = 0; k < 3; k++) begin
            obs = {busy_o, ser_data_val_o, ser_data_o};
            chk_cnt++;
            if (obs !== 3'b000) $display("FAIL partial_idle%0d obs=%b exp=000", k, obs);
            else pass_cnt++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_short_len();
        logic [2:0] obs;
        data_i = 16'hFFFF; data_mod_i = 4'd1; data_val_i = 1'b1;
        @(negedge clk_i);
        obs = {busy_o, ser_data_val_o, ser_data_o};
        chk_cnt++;
        if (obs !== 3'b000) $display("FAIL short_len1 obs=%b exp=000", obs);
        else pass_cnt++;
        data_mod_i = 4'd2;
        @(negedge clk_i);
        data_val_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            obs = {busy_o, ser_data_val_o, ser_data_o};
            chk_cnt++;
            if (obs !== 3'b000) $display("FAIL short_len_cyc%0d obs=%b exp=000", k, obs);
            else pass_cnt++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        logic [2:0]  obs, exp;
        a = 16'h8421;
        b = 16'hB000;
        data_i = a; data_mod_i = 4'd0; data_val_i = 1'b1;
        @(negedge clk_i);
        data_i = b; data_mod_i = 4'd4;
        for (int k = 0; k < 16; k++) begin
            exp = {2'b11, a[15-k]};
            obs = {busy_o, ser_data_val_o, ser_data_o};
            chk_cnt++;
            if (obs !== exp) $display("FAIL b2b_first bit%0d obs=%b exp=%b", k, obs, exp);
            else pass_cnt++;
            @(negedge clk_i);
        end
        obs = {busy_o, ser_data_val_o, ser_data_o};
        chk_cnt++;
        if (obs !== 3'b000) $display("FAIL b2b_gap obs=%b exp=000", obs);
        else pass_cnt++;
        @(negedge clk_i);
        data_val_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp = {2'b11, b[15-k]};
            obs = {busy_o, ser_data_val_o, ser_data_o};
            chk_cnt++;
            if (obs !== exp) $display("FAIL b2b_second bit%0d obs=%b exp=%b", k, obs, exp);
            else pass_cnt++;
            @(negedge clk_i);
        end
        obs = {busy_o, ser_data_val_o, ser_data_o};
        chk_cnt++;
        if (obs !== 3'b000) $display("FAIL b2b_end obs=%b exp=000", obs);
        else pass_cnt++;
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_word();
        logic [2:0]  obs, exp;
        logic [15:0] w;
        data_i = 16'hFFFF; data_mod_i = 4'd0; data_val_i = 1'b1;
        @(negedge clk_i);
        data_val_i = 1'b0;
        for (int k = 0; k < 5; k++) @(negedge clk_i);
        obs = {busy_o, ser_data_val_o, ser_data_o};
        chk_cnt++;
        if (obs !== 3'b111) $display("FAIL mid_word_bit5 obs=%b exp=111", obs);
        else pass_cnt++;
        #1 arst_n_i = 1'b0;
        #1;
        obs = {busy_o, ser_data_val_o, ser_data_o};
        chk_cnt++;
        if (obs !== 3'b000) $display("FAIL mid_word_async obs=%b exp=000", obs);
        else pass_cnt++;
        repeat (2) @(negedge clk_i);
        #2 arst_n_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            obs = {busy_o, ser_data_val_o, ser_data_o};
            chk_cnt++;
            if (obs !== 3'b000) $display("FAIL mid_word_no_resume%0d obs=%b exp=000", k, obs);
            else pass_cnt++;
        end
        // A request already waiting when reset lifts is taken on the first edge.
        w = 16'hA000;
        arst_n_i = 1'b0;
        data_i = w; data_mod_i = 4'd3; data_val_i = 1'b1;
        #2 arst_n_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            data_val_i = 1'b0;
            exp = {2'b11, w[15-k]};
            obs = {busy_o, ser_data_val_o, ser_data_o};
            chk_cnt++;
            if (obs !== exp) $display("FAIL post_reset_req bit%0d obs=%b exp=%b", k, obs, exp);
            else pass_cnt++;
        end
        @(negedge clk_i);
        obs = {busy_o, ser_data_val_o, ser_data_o};
        chk_cnt++;
        if (obs !== 3'b000) $display("FAIL post_reset_idle obs=%b exp=000", obs);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic       q[$];
        logic       m_busy;
        logic [2:0] obs, exp;
        int         len;
        m_busy = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            data_i     = 16'($urandom);
            data_mod_i = 4'($urandom_range(0, 15));
            data_val_i = 1'($urandom_range(0, 1));
            len = (data_mod_i == 4'd0) ? 16 : int'(data_mod_i);
            if (!m_busy && data_val_i && len >= 3)
                for (int k = 0; k < len; k++) q.push_back(data_i[15-k]);
            if (q.size() > 0) begin
                exp = {2'b11, q.pop_front()};
                m_busy = 1'b1;
            end else begin
                exp = 3'b000;
                m_busy = 1'b0;
            end
            @(negedge clk_i);
            obs = {busy_o, ser_data_val_o, ser_data_o};
            chk_cnt++;
            if (obs !== exp) $display("FAIL random cyc%0d obs=%b exp=%b", n, obs, exp);
            else pass_cnt++;
        end
        data_val_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial_word();
        test_short_len();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
